mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single `mem` QSPI memory controller between the instruction-fetch requester (port A) and the data-access requester (port B). It serialises the requests with round-robin fairness, drives `mem`'s op/address/data inputs for exactly one transaction at a time, and returns read data with a one-cycle acknowledge to the winning requester. A watchdog aborts transactions whose `op_done` never arrives.

## Interface
- `DATA_BUS_WIDTH`, 8: data width of both ports and of `mem`.
- `ADDRESS_WIDTH`, 16: address width of both ports.
- `TIMEOUT`, 255: maximum cycles in BUSY before abort; range 1..255.

- `clock`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `a_req` / `b_req`  in  1  request from port A / B.
- `a_we` / `b_we`  in  1  1 = write, 0 = read.
- `a_addr` / `b_addr`  in  ADDRESS_WIDTH  target address.
- `a_wdata` / `b_wdata`  in  DATA_BUS_WIDTH  write data.
- `a_ack` / `b_ack`  out  1  one-cycle completion pulse.
- `a_err` / `b_err`  out  1  valid with ack; 1 = transaction timed out.
- `rdata`  out  DATA_BUS_WIDTH  read data, shared, valid while either ack is high.
- `mem_op`  out  2  to `mem` op: 0 = NOP, 1 = READ, 2 = WRITE.
- `mem_addr`  out  ADDRESS_WIDTH  address to `mem`.
- `mem_wdata`  out  DATA_BUS_WIDTH  to `mem` `bus_data_in`.
- `mem_done`  in  1  from `mem` `op_done_out`.
- `mem_rdata`  in  DATA_BUS_WIDTH  from `mem` `bus_data_out`.
- `busy`  out  1  high in BUSY and RESP.

## Operation
- States: IDLE, BUSY, RESP. Registers: state, `last` (last granted port, 0 = A), grant, 8-bit watchdog counter, captured rdata.
- IDLE: neither req -> stay. One req -> grant that port. Both -> grant the port not equal to `last`. On grant: latch grant, `mem_op`/`mem_addr`/`mem_wdata` from the winner (`mem_op` = we ? 2 : 1), clear watchdog, go BUSY.
- BUSY: `mem_op`, `mem_addr`, `mem_wdata` held stable. Watchdog increments each cycle. `mem_done` = 1 -> capture `mem_rdata` (writes too), err = 0, go RESP. Watchdog reaches `TIMEOUT` with no `mem_done` -> rdata = 0, err = 1, go RESP. `mem_done` wins if both occur the same cycle.
- RESP (one cycle): `mem_op` = NOP; winner's ack = 1 with err; `last` <= grant; next state IDLE.
- Requester contract: hold req, we, addr, wdata stable until its ack. Input changes after grant are ignored; a req dropped early still gets its ack.
- The losing requester's req stays pending and is granted at the next IDLE evaluation.
- `mem_done` outside BUSY is ignored.
- Reset (any state, including mid-transaction): state = IDLE, `last` = 1 (A wins the first tie), `mem_op` = 0, `mem_addr` = 0, `mem_wdata` = 0, `a_ack` = `b_ack` = 0, `a_err` = `b_err` = 0, `rdata` = 0, `busy` = 0, watchdog = 0. A reset-aborted transaction gets no ack.

## Timing
- All outputs are registered.
- req sampled in IDLE at edge N -> `mem_op` ≠ NOP and `busy` = 1 from cycle N+1.
- `mem_done` sampled at edge M -> ack, err and rdata valid during cycle M+1 only; `mem_op` = NOP in cycle M+1; IDLE in cycle M+2.
- Minimum transaction (`mem_done` in the first BUSY cycle): req to ack = 2 cycles. Arbitration gap between back-to-back grants: 1 RESP cycle + 1 IDLE cycle. A req still high during its own ack cycle is re-evaluated in the following IDLE as a new request.
- Timeout: with no `mem_done`, RESP with err = 1 is entered after `TIMEOUT` BUSY cycles.

## Test plan
- Single read, port A: a_addr = 0x0010, `mem_done` 3 cycles after `mem_op` = 1, `mem_rdata` = 0xA5 -> `a_ack` one pulse with `rdata` = 0xA5, `a_err` = 0; `mem_addr` = 0x0010 stable throughout BUSY.
- Write, port B: b_addr = 0x8000, b_wdata = 0x3C -> `mem_op` = 2, `mem_wdata` = 0x3C; `b_ack` pulse; `a_ack` stays 0.
- Simultaneous requests after reset, held high -> grants alternate A, B, A, B over 4 transactions; exactly 1 ack per transaction.
- Watchdog, `TIMEOUT` = 4, `mem_done` never asserted -> ack with err = 1 and `rdata` = 0 after 4 BUSY cycles; the next request proceeds normally.
- Reset asserted in BUSY -> next cycle all outputs at reset values; no ack; a new request afterwards completes normally.
- Minimum latency, `mem_done` high in the first BUSY cycle -> ack 2 cycles after req is sampled; a `mem_done` pulse injected in IDLE produces no ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one QSPI memory controller (`mem`) between two requesters:
//   port A = instruction fetch, port B = data access.
// Requests are serialised with round-robin fairness. Exactly one transaction
// is presented to `mem` at a time. The winner receives a one-cycle ack
// together with an error flag and the shared read data. A watchdog aborts any
// transaction whose `mem_done` never arrives.
//
// Parameters
//   DATA_BUS_WIDTH : data width of both ports and of `mem`
//   ADDRESS_WIDTH  : address width of both ports
//   TIMEOUT        : BUSY cycles allowed before abort (1..255)
//
// Ports
//   clock, reset          : system clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata : port A request, direction, address, write data
//   b_req/b_we/b_addr/b_wdata : port B request, direction, address, write data
//   a_ack/a_err, b_ack/b_err  : one-cycle completion pulse and timeout flag
//   rdata                 : read data, valid while either ack is high
//   mem_op/mem_addr/mem_wdata : command to `mem` (0 NOP, 1 READ, 2 WRITE)
//   mem_done/mem_rdata    : completion and read data from `mem`
//   busy                  : high while a transaction is in BUSY or RESP
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clock,
  input  logic                      reset,

  input  logic                      a_req,
  input  logic                      a_we,
  input  logic [ADDRESS_WIDTH-1:0]  a_addr,
  input  logic [DATA_BUS_WIDTH-1:0] a_wdata,
  output logic                      a_ack,
  output logic                      a_err,

  input  logic                      b_req,
  input  logic                      b_we,
  input  logic [ADDRESS_WIDTH-1:0]  b_addr,
  input  logic [DATA_BUS_WIDTH-1:0] b_wdata,
  output logic                      b_ack,
  output logic                      b_err,

  output logic [DATA_BUS_WIDTH-1:0] rdata,

  output logic [1:0]                mem_op,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
  input  logic                      mem_done,
  input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,

  output logic                      busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  // Watchdog value seen at the clock edge that closes the TIMEOUT-th BUSY
  // cycle: the counter is cleared on grant and counts completed BUSY cycles.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  // Port encoding used by grant and last: 0 = port A, 1 = port B.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // mem command for a requester direction bit.
  function automatic logic [1:0] op_of(input logic we);
    if (we) begin
      return OP_WRITE;
    end else begin
      return OP_READ;
    end
  endfunction

  // Round-robin pick: a lone requester wins; on a tie the port that was
  // not served last wins. Only meaningful when at least one req is high.
  function automatic logic pick_winner(input logic req_a,
                                       input logic req_b,
                                       input logic last_port);
    if (req_a && req_b) begin
      return ~last_port;
    end else if (req_b) begin
      return PORT_B;
    end else begin
      return PORT_A;
    end
  endfunction

  state_t                      state_q,     state_d;
  logic                        last_q,      last_d;
  logic                        grant_q,     grant_d;
  logic [7:0]                  wd_q,        wd_d;
  logic [DATA_BUS_WIDTH-1:0]   rdata_q,     rdata_d;
  logic [1:0]                  mem_op_q,    mem_op_d;
  logic [ADDRESS_WIDTH-1:0]    mem_addr_q,  mem_addr_d;
  logic [DATA_BUS_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                        a_ack_q,     a_ack_d;
  logic                        b_ack_q,     b_ack_d;
  logic                        a_err_q,     a_err_d;
  logic                        b_err_q,     b_err_d;
  logic                        busy_q,      busy_d;

  logic                        winner_s;

  // Winner of the current IDLE evaluation.
  always_comb begin
    winner_s = pick_winner(a_req, b_req, last_q);
  end

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    wd_d        = wd_q;
    rdata_d     = rdata_q;
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    // Ack and err are single-cycle pulses; they only rise on BUSY exit.
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_err_d     = 1'b0;
    b_err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (a_req || b_req) begin
          // Latch the winner's command; later input changes are ignored.
          grant_d = winner_s;
          if (winner_s == PORT_B) begin
            mem_op_d    = op_of(b_we);
            mem_addr_d  = b_addr;
            mem_wdata_d = b_wdata;
          end else begin
            mem_op_d    = op_of(a_we);
            mem_addr_d  = a_addr;
            mem_wdata_d = a_wdata;
          end
          wd_d    = 8'd0;
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        // Completion is checked first so it wins over a same-cycle timeout.
        if (mem_done) begin
          rdata_d  = mem_rdata;
          a_ack_d  = (grant_q == PORT_A);
          b_ack_d  = (grant_q == PORT_B);
          mem_op_d = OP_NOP;
          state_d  = ST_RESP;
        end else if (wd_q == WD_LAST) begin
          rdata_d  = '0;
          a_ack_d  = (grant_q == PORT_A);
          b_ack_d  = (grant_q == PORT_B);
          a_err_d  = (grant_q == PORT_A);
          b_err_d  = (grant_q == PORT_B);
          mem_op_d = OP_NOP;
          state_d  = ST_RESP;
        end else begin
          wd_d    = wd_q + 8'd1;
          state_d = ST_BUSY;
        end
      end

      ST_RESP: begin
        // Fairness history advances only once the transaction is finished.
        last_d   = grant_q;
        mem_op_d = OP_NOP;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        mem_op_d = OP_NOP;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= PORT_B;
      grant_q     <= PORT_A;
      wd_q        <= 8'd0;
      rdata_q     <= '0;
      mem_op_q    <= OP_NOP;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      wd_q        <= wd_d;
      rdata_q     <= rdata_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_err_q     <= a_err_d;
      b_err_q     <= b_err_d;
      busy_q      <= busy_d;
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_err     = a_err_q;
  assign b_err     = b_err_q;
  assign rdata     = rdata_q;
  assign mem_op    = mem_op_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter built with TIMEOUT = 4. Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, a_err, b_ack, b_err;
  logic [DW-1:0] rdata;
  logic [1:0]    mem_op;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int tests_run = 0;
  int tests_failed = 0;

  mem_arbiter #(
    .DATA_BUS_WIDTH(DW),
    .ADDRESS_WIDTH (AW),
    .TIMEOUT       (TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_ack    (a_ack),
    .a_err    (a_err),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_ack    (b_ack),
    .b_err    (b_err),
    .rdata    (rdata),
    .mem_op   (mem_op),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_done (mem_done),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every output at its reset value, no ack in flight.
  task automatic chk_reset_vals(input string tag);
    chk({tag, ".mem_op"},    32'(mem_op),    32'h0);
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'h0);
    chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, ".busy"},      32'(busy),      32'h0);
    chk({tag, ".acks"},      32'({a_ack, b_ack}), 32'h0);
    chk({tag, ".errs"},      32'({a_err, b_err}), 32'h0);
    chk({tag, ".rdata"},     32'(rdata),     32'h0);
  endtask

  initial begin
    logic exp_b;
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 16'h0000; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 16'h0000; b_wdata = 8'h00;
    mem_done = 1'b0; mem_rdata = 8'h00;

    // ---- Reset state ------------------------------------------------------
    tick(); tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();

    // ---- Single read on port A, done in 4th BUSY cycle (ties watchdog) ----
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
    tick();
    chk("rdA.op",   32'(mem_op),   32'h1);
    chk("rdA.busy", 32'(busy),     32'h1);
    chk("rdA.addr1", 32'(mem_addr), 32'h0010);
    a_addr = 16'h1234;               // ignored after grant
    tick();
    chk("rdA.addr2", 32'(mem_addr), 32'h0010);
    chk("rdA.noack2", 32'(a_ack),  32'h0);
    tick();
    chk("rdA.addr3", 32'(mem_addr), 32'h0010);
    tick();
    chk("rdA.addr4", 32'(mem_addr), 32'h0010);
    chk("rdA.op4",   32'(mem_op),   32'h1);
    mem_done = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_done = 1'b0; a_req = 1'b0;
    chk("rdA.ack",   32'(a_ack),  32'h1);
    chk("rdA.err",   32'(a_err),  32'h0);
    chk("rdA.rdata", 32'(rdata),  32'hA5);
    chk("rdA.back",  32'(b_ack),  32'h0);
    chk("rdA.opnop", 32'(mem_op), 32'h0);
    chk("rdA.busyR", 32'(busy),   32'h1);
    tick();
    chk("rdA.ackoff", 32'(a_ack), 32'h0);
    chk("rdA.idle",   32'(busy),  32'h0);

    // ---- Write on port B ---------------------------------------------------
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h8000; b_wdata = 8'h3C;
    tick();
    chk("wrB.op",    32'(mem_op),    32'h2);
    chk("wrB.addr",  32'(mem_addr),  32'h8000);
    chk("wrB.wdata", 32'(mem_wdata), 32'h3C);
    mem_done = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_done = 1'b0; b_req = 1'b0;
    chk("wrB.ack",   32'(b_ack), 32'h1);
    chk("wrB.aack",  32'(a_ack), 32'h0);
    chk("wrB.err",   32'(b_err), 32'h0);
    chk("wrB.rdata", 32'(rdata), 32'h77);
    tick();
    chk("wrB.ackoff", 32'(b_ack), 32'h0);

    // ---- Round robin after reset, both requests held ---------------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0100;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0200;
    for (int t = 0; t < 4; t++) begin
      exp_b = (t % 2 == 1);
      tick();                                    // grant edge
      chk($sformatf("rr%0d.addr", t), 32'(mem_addr), exp_b ? 32'h0200 : 32'h0100);
      mem_done = 1'b1; mem_rdata = 8'(8'h10 + t);
      tick();                                    // RESP
      mem_done = 1'b0;
      chk($sformatf("rr%0d.aack", t), 32'(a_ack), exp_b ? 32'h0 : 32'h1);
      chk($sformatf("rr%0d.back", t), 32'(b_ack), exp_b ? 32'h1 : 32'h0);
      chk($sformatf("rr%0d.rdata", t), 32'(rdata), 32'h10 + 32'(t));
      tick();                                    // IDLE
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("rr.quiet", 32'(busy), 32'h0);

    // ---- Watchdog: TIMEOUT = 4, no mem_done ------------------------------
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0042;
    tick();
    for (int c = 1; c <= TO; c++) begin
      chk($sformatf("wd.noack%0d", c), 32'(a_ack), 32'h0);
      chk($sformatf("wd.busy%0d", c),  32'(busy),  32'h1);
      if (c < TO) begin
        tick();
      end else begin
        chk("wd.op4", 32'(mem_op), 32'h1);
      end
    end
    tick();
    a_req = 1'b0;
    chk("wd.ack",   32'(a_ack),  32'h1);
    chk("wd.err",   32'(a_err),  32'h1);
    chk("wd.rdata", 32'(rdata),  32'h0);
    chk("wd.opnop", 32'(mem_op), 32'h0);
    tick();
    chk("wd.erroff", 32'(a_err), 32'h0);
    a_req = 1'b1; a_addr = 16'h0043;
    tick();
    chk("wd.next.addr", 32'(mem_addr), 32'h0043);
    mem_done = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_done = 1'b0; a_req = 1'b0;
    chk("wd.next.ack",   32'(a_ack), 32'h1);
    chk("wd.next.err",   32'(a_err), 32'h0);
    chk("wd.next.rdata", 32'(rdata), 32'h5A);
    tick();

    // ---- Reset asserted mid-transaction -----------------------------------
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h1111; b_wdata = 8'h99;
    tick();
    chk("rst.busy", 32'(busy), 32'h1);
    chk("rst.op",   32'(mem_op), 32'h2);
    reset = 1'b1;
    tick();
    reset = 1'b0; b_req = 1'b0;
    chk_reset_vals("rst.mid");
    tick();
    chk("rst.noack1", 32'({a_ack, b_ack}), 32'h0);
    tick();
    chk("rst.noack2", 32'({a_ack, b_ack}), 32'h0);
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h2222;
    tick();
    chk("rst.new.op", 32'(mem_op), 32'h1);
    mem_done = 1'b1; mem_rdata = 8'hC3;
    tick();
    mem_done = 1'b0; b_req = 1'b0;
    chk("rst.new.ack",   32'(b_ack), 32'h1);
    chk("rst.new.rdata", 32'(rdata), 32'hC3);
    tick();

    // ---- mem_done in IDLE is ignored --------------------------------------
    mem_done = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_done = 1'b0;
    tick();
    chk("idle.done.acks", 32'({a_ack, b_ack}), 32'h0);
    chk("idle.done.busy", 32'(busy),   32'h0);
    chk("idle.done.op",   32'(mem_op), 32'h0);

    // ---- Minimum latency: done in first BUSY cycle ------------------------
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0777;
    tick();                                      // req sampled (edge N)
    mem_done = 1'b1; mem_rdata = 8'h81;
    chk("min.n1.ack", 32'(a_ack), 32'h0);
    tick();                                      // cycle N+2
    mem_done = 1'b0; a_req = 1'b0;
    chk("min.n2.ack",   32'(a_ack), 32'h1);
    chk("min.n2.rdata", 32'(rdata), 32'h81);
    tick();
    chk("min.n3.ack", 32'(a_ack), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
